systolic_mac_array: RTL and testbench

N×N output-stationary systolic multiply-accumulate grid that sits directly downstream of the operand A and operand B registers. It consumes their skewed lane buses, computes C = A·B in place, and owns the step sequencer. That sequencer produces the counter and start strobe that the operand registers use to emit their skewed data. Results are read back per element by the APB read path.

---
 rtl/systolic_mac_array_if.sv | 32 +++
 rtl/systolic_mac_array.sv | 140 ++++++++++++++
 tb/tb_systolic_mac_array.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mac_array_if.sv
// Bundles the operand lanes, sequencer outputs and result read port of the
// systolic MAC grid so the grid and its driver share one set of widths.
interface systolic_mac_array_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
);
  localparam int N  = BUS_WIDTH / DATA_WIDTH;
  localparam int CW = (3 * N - 2 > 1) ? $clog2(3 * N - 2) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic                 start_i;
  logic [BUS_WIDTH-1:0] a_col_i;
  logic [BUS_WIDTH-1:0] b_row_i;
  logic [CW-1:0]        counter_o;
  logic                 busy_o;
  logic                 done_o;
  logic [RW-1:0]        res_row_i;
  logic [RW-1:0]        res_col_i;
  logic [ACC_WIDTH-1:0] res_data_o;
  logic [N*N-1:0]       ovf_o;

  modport master (
    output start_i, a_col_i, b_row_i, res_row_i, res_col_i,
    input  counter_o, busy_o, done_o, res_data_o, ovf_o
  );

  modport slave (
    input  start_i, a_col_i, b_row_i, res_row_i, res_col_i,
    output counter_o, busy_o, done_o, res_data_o, ovf_o
  );
endinterface

// File: rtl/systolic_mac_array.sv
// Output-stationary N x N systolic MAC grid with its own step sequencer;
// A flows left-to-right along rows, B top-to-bottom along columns.
module systolic_mac_array #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  systolic_mac_array_if.slave bus
);
  localparam int N  = BUS_WIDTH / DATA_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int CW = (3 * N - 2 > 1) ? $clog2(3 * N - 2) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(3 * N - 3);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] counter_reg, counter_next;
  logic          clear;
  logic          mac_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    clear        = 1'b0;
    mac_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          state_next   = RUN;
          counter_next = '0;
          clear        = 1'b1;
        end
      end
      RUN: begin
        // Step 0 data only arrives on the following cycle, so skip counter 0.
        mac_en = (counter_reg != '0);
        if (counter_reg == LAST_STEP) begin
          state_next   = FLUSH;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + CW'(1);
        end
      end
      FLUSH: begin
        mac_en     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  assign bus.counter_o = counter_reg;
  assign bus.busy_o    = (state_reg == RUN);
  assign bus.done_o    = (state_reg == DONE);

  logic signed [DW-1:0] a_reg [N][N];
  logic signed [DW-1:0] b_reg [N][N];
  logic signed [AW-1:0] acc_reg [N][N];
  logic                 ovf_reg [N][N];
  logic [N*N-1:0]       ovf_flat;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic signed [DW-1:0]   a_in;
        logic signed [DW-1:0]   b_in;
        logic signed [2*DW-1:0] prod;
        logic signed [AW-1:0]   prod_ext;
        logic signed [AW-1:0]   sum_next;
        logic                   ovf_hit;

        if (gj == 0) begin : g_a_edge
          assign a_in = bus.a_col_i[gi*DW +: DW];
        end else begin : g_a_inner
          assign a_in = a_reg[gi][gj-1];
        end

        if (gi == 0) begin : g_b_edge
          assign b_in = bus.b_row_i[gj*DW +: DW];
        end else begin : g_b_inner
          assign b_in = b_reg[gi-1][gj];
        end

        assign prod     = a_in * b_in;
        assign prod_ext = prod;
        assign sum_next = acc_reg[gi][gj] + prod_ext;
        // Signed overflow: addends agree in sign but the wrapped sum does not.
        assign ovf_hit  = (acc_reg[gi][gj][AW-1] == prod_ext[AW-1]) &&
                          (sum_next[AW-1] != acc_reg[gi][gj][AW-1]);

        always_ff @(posedge clk_i) begin
          if (rst_i || clear) begin
            a_reg[gi][gj]   <= '0;
            b_reg[gi][gj]   <= '0;
            acc_reg[gi][gj] <= '0;
            ovf_reg[gi][gj] <= 1'b0;
          end else if (mac_en) begin
            a_reg[gi][gj]   <= a_in;
            b_reg[gi][gj]   <= b_in;
            acc_reg[gi][gj] <= sum_next;
            if (ovf_hit) begin
              ovf_reg[gi][gj] <= 1'b1;
            end
          end
        end

        assign ovf_flat[gi*N+gj] = ovf_reg[gi][gj];
      end
    end
  endgenerate

  assign bus.ovf_o      = ovf_flat;
  assign bus.res_data_o = acc_reg[bus.res_row_i][bus.res_col_i];
endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomised scoreboard bench for systolic_mac_array: emulates the skewing
// operand registers and checks C = A*B against a plain matrix-product model.
module tb_systolic_mac_array;
  localparam int BW = 16;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int N  = BW / DW;
  localparam int CW = (3 * N - 2 > 1) ? $clog2(3 * N - 2) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));

  typedef struct packed {
    logic [N*N*AW-1:0] c_flat;
    logic [N*N-1:0]    ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  systolic_mac_array_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  systolic_mac_array #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   n_txn        = 0;
  exp_t exp_q[$];
  int   cur_a [N][N];
  int   cur_b [N][N];

  task automatic check(input string name, input longint act, input longint req);
    n_compared++;
    if (act != req) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: row-by-column dot product accumulated in k order with wrap.
  function automatic exp_t model();
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int acc;
        int s;
        logic signed [AW-1:0] w;
        acc = 0;
        for (int k = 0; k < N; k++) begin
          s = acc + cur_a[i][k] * cur_b[k][j];
          if (s > AMAX || s < AMIN) e.ovf[i*N+j] = 1'b1;
          w = AW'(s);
          acc = int'(w);
        end
        e.c_flat[(i*N+j)*AW +: AW] = AW'(acc);
      end
    end
    return e;
  endfunction

  task automatic read_res(input int i, input int j, output logic [AW-1:0] v);
    bus.res_row_i = RW'(i);
    bus.res_col_i = RW'(j);
    #1;
    v = bus.res_data_o;
  endtask

  // Operand-register emulation: step k data appears the cycle after counter k.
  initial begin : driver
    logic          s_busy;
    int            s_k;
    logic [BW-1:0] a_v;
    logic [BW-1:0] b_v;
    bus.a_col_i = '0;
    bus.b_row_i = '0;
    forever begin
      @(negedge clk);
      s_busy = bus.busy_o;
      s_k    = int'(bus.counter_o);
      @(posedge clk);
      #1;
      a_v = '0;
      b_v = '0;
      if (s_busy) begin
        for (int r = 0; r < N; r++) begin
          if (s_k - r >= 0 && s_k - r < N) begin
            a_v[r*DW +: DW] = DW'(cur_a[r][s_k-r]);
            b_v[r*DW +: DW] = DW'(cur_b[s_k-r][r]);
          end
        end
      end
      bus.a_col_i = a_v;
      bus.b_row_i = b_v;
    end
  end

  initial begin : monitor
    exp_t            e;
    logic [AW-1:0]   v;
    forever begin
      @(negedge clk);
      if (bus.done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          n_txn++;
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              read_res(i, j, v);
              check($sformatf("txn%0d_c%0d%0d", n_txn, i, j),
                    longint'($signed(v)), longint'($signed(e.c_flat[(i*N+j)*AW +: AW])));
            end
          end
          check($sformatf("txn%0d_ovf", n_txn), longint'(bus.ovf_o), longint'(e.ovf));
          $display("txn %0d: result checked, ovf=%b", n_txn, bus.ovf_o);
        end
      end
    end
  end

  task automatic launch(input bit push);
    if (push) exp_q.push_back(model());
    @(posedge clk);
    #1 bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = bus.done_o;
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic check_all_zero(input string name);
    logic [AW-1:0] v;
    check({name, "_busy"}, longint'(bus.busy_o), 0);
    check({name, "_done"}, longint'(bus.done_o), 0);
    check({name, "_counter"}, longint'(bus.counter_o), 0);
    check({name, "_ovf"}, longint'(bus.ovf_o), 0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        read_res(i, j, v);
        check($sformatf("%s_res%0d%0d", name, i, j), longint'(v), 0);
      end
    end
  endtask

  initial begin : main
    bit hit;
    bus.start_i   = 1'b0;
    bus.res_row_i = '0;
    bus.res_col_i = '0;
    cur_a = '{default: 0};
    cur_b = '{default: 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Basic multiply with cycle-exact handshake and a stray start mid-run.
    cur_a = '{'{1, 2}, '{3, 4}};
    cur_b = '{'{5, 6}, '{7, 8}};
    launch(1'b1);
    for (int c = 1; c <= 3 * N - 2; c++) begin
      @(negedge clk);
      if (c == 3) bus.start_i = 1'b0;
      check($sformatf("run_busy_c%0d", c), longint'(bus.busy_o), 1);
      check($sformatf("run_counter_c%0d", c), longint'(bus.counter_o), longint'(c - 1));
      if (c == 2) bus.start_i = 1'b1;
    end
    @(negedge clk);
    check("flush_busy", longint'(bus.busy_o), 0);
    check("flush_done", longint'(bus.done_o), 0);
    @(negedge clk);
    check("done_pulse", longint'(bus.done_o), 1);
    @(negedge clk);
    check("done_single", longint'(bus.done_o), 0);
    check("idle_busy", longint'(bus.busy_o), 0);

    // Signed operands, then overflow, started back-to-back after done.
    cur_a = '{'{-1, 2}, '{3, -4}};
    cur_b = '{'{5, -6}, '{-7, 8}};
    launch(1'b1);
    wait_done("signed");
    cur_a = '{'{-128, -128}, '{0, 0}};
    cur_b = '{'{-128, 0}, '{-128, 0}};
    launch(1'b1);
    wait_done("ovf");
    cur_a = '{'{1, 2}, '{3, 4}};
    cur_b = '{'{5, 6}, '{7, 8}};
    launch(1'b1);
    wait_done("ovf_clear");

    // Reset asserted while the counter shows 2.
    cur_a = '{'{9, -9}, '{7, 5}};
    cur_b = '{'{3, 1}, '{-2, 6}};
    launch(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (c > 0) @(negedge clk);
      hit = bus.busy_o && (bus.counter_o == CW'(2));
    end
    if (!hit) check("midrun_counter2_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrun_reset");
    launch(1'b1);
    wait_done("after_reset");

    // Randomised back-to-back runs.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          cur_a[i][j] = int'($urandom_range(0, 255)) - 128;
          cur_b[i][j] = int'($urandom_range(0, 255)) - 128;
        end
      end
      launch(1'b1);
      wait_done($sformatf("rand%0d", t));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
